axi_lite_reg_slave: RTL and testbench

- AXI4-Lite responder holding a four-word register bank. Sits on one master port (m1 or m2) of the bus interconnect as the endpoint that bus transactions target.
- Accepts single-beat writes and reads with independent write and read channels.
- Returns OKAY/SLVERR responses and keeps a read-only count of completed writes.

---
 rtl/axi_lite_reg_slave.sv | 209 ++++++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite responder: three RW data registers plus a read-only count of
// completed OKAY writes. Write and read channels run as independent FSMs.
module axi_lite_reg_slave #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RESP_WIDTH = 3,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [RESP_WIDTH-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    // True when the address misses the 16-byte window or is not word aligned
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] a32;
        a32 = 32'(a);
        return (a32 < BASE_ADDR) || ((a32 - BASE_ADDR) >= 32'd16) || (a[1:0] != 2'b00);
    endfunction

    // Word index of the address within the window
    function automatic logic [1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return 2'((32'(a) - BASE_ADDR) >> 2);
    endfunction

    wstate_t                 r_wstate;
    rstate_t                 r_rstate;
    logic                    r_awready;
    logic                    r_wready;
    logic                    r_aw_held;
    logic                    r_w_held;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [NUM_BYTES-1:0]    r_wstrb;
    logic [RESP_WIDTH-1:0]   r_bresp;
    logic                    r_bvalid;
    logic                    r_arready;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [RESP_WIDTH-1:0]   r_rresp;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_reg0;
    logic [DATA_WIDTH-1:0]   r_reg1;
    logic [DATA_WIDTH-1:0]   r_reg2;
    logic [DATA_WIDTH-1:0]   r_wcount;

    logic [1:0]              w_wr_idx;
    logic                    w_wr_ok;
    logic [1:0]              w_rd_idx;
    logic                    w_rd_err;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic                    w_unused_strb;

    // The strobe MSB only exists to match the bus port width
    assign w_unused_strb = s_axi_wstrb[NUM_BYTES];

    // Write decode: OKAY only for an aligned in-window access to REG0..REG2
    assign w_wr_idx = addr_idx(r_awaddr);
    assign w_wr_ok  = !addr_err(r_awaddr) && (w_wr_idx != 2'd3);

    // Read decode and register mux from current state
    assign w_rd_idx = addr_idx(s_axi_araddr);
    assign w_rd_err = addr_err(s_axi_araddr);
    always_comb begin
        w_rd_data = '0;
        case (w_rd_idx)
            2'd0:    w_rd_data = r_reg0;
            2'd1:    w_rd_data = r_reg1;
            2'd2:    w_rd_data = r_reg2;
            default: w_rd_data = r_wcount;
        endcase
    end

    // Write channel FSM: latch AW/W beats, commit, then hold the response
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= '0;
            r_bvalid  <= 1'b0;
            r_reg0    <= '0;
            r_reg1    <= '0;
            r_reg2    <= '0;
            r_wcount  <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (r_awready && s_axi_awvalid) begin
                        r_aw_held <= 1'b1;
                        r_awaddr  <= s_axi_awaddr;
                        r_awready <= 1'b0;
                    end else begin
                        r_awready <= !r_aw_held;
                    end
                    if (r_wready && s_axi_wvalid) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= s_axi_wdata;
                        r_wstrb  <= s_axi_wstrb[NUM_BYTES-1:0];
                        r_wready <= 1'b0;
                    end else begin
                        r_wready <= !r_w_held;
                    end
                    if (r_aw_held && r_w_held) begin
                        r_wstate <= W_EXEC;
                    end
                end
                W_EXEC: begin
                    if (w_wr_ok) begin
                        for (int b = 0; b < NUM_BYTES; b++) begin
                            if (r_wstrb[b]) begin
                                case (w_wr_idx)
                                    2'd0:    r_reg0[b*8 +: 8] <= r_wdata[b*8 +: 8];
                                    2'd1:    r_reg1[b*8 +: 8] <= r_wdata[b*8 +: 8];
                                    default: r_reg2[b*8 +: 8] <= r_wdata[b*8 +: 8];
                                endcase
                            end
                        end
                        r_wcount <= r_wcount + DATA_WIDTH'(1);
                    end
                    r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                    r_bvalid <= 1'b1;
                    r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: capture on AR handshake, hold until R handshake
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= '0;
            r_rvalid  <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (r_arready && s_axi_arvalid) begin
                        r_rdata   <= w_rd_err ? '0 : w_rd_data;
                        r_rresp   <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_arready = r_arready;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rvalid  = r_rvalid;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave with hand-computed expected values.
module tb_axi_lite_reg_slave;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [4:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [2:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [2:0]  rresp;
    logic        rvalid;
    logic        rready;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axi_lite_reg_slave #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .RESP_WIDTH(3),
        .BASE_ADDR (0)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(aresetn),
        .s_axi_awaddr (awaddr),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bresp  (bresp),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_araddr (araddr),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present AW and W together and retire each beat on its own handshake
    task automatic start_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s);
        logic aw_done;
        logic w_done;
        logic aw_hs;
        logic w_hs;
        int   n;
        aw_done = 1'b0;
        w_done  = 1'b0;
        n       = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_handshakes", 32'(aw_done && w_done), 32'd1);
    endtask

    task automatic wait_bvalid();
        int n;
        n = 0;
        while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
        chk("bvalid_seen", 32'(bvalid), 32'd1);
    endtask

    task automatic write_txn(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                             output logic [2:0] resp);
        bready = 1'b1;
        start_write(a, d, s);
        wait_bvalid();
        resp = bresp;
        @(posedge clk); #1;
    endtask

    task automatic read_txn(input logic [7:0] a, output logic [31:0] d, output logic [2:0] r);
        int n;
        n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
        chk("rd_rvalid", 32'(rvalid), 32'd1);
        d = rdata;
        r = rresp;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [2:0]  rr;
        logic [2:0]  br;

        aresetn = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;

        // Reset values
        #12;
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready",  32'(wready),  32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_bresp",   32'(bresp),   32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_rresp",   32'(rresp),   32'd0);
        chk("rst_rdata",   rdata,        32'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_awready", 32'(awready), 32'd1);
        chk("idle_wready",  32'(wready),  32'd1);
        chk("idle_arready", 32'(arready), 32'd1);

        // AW and W in the same cycle; bvalid two cycles after the handshake
        awaddr = 8'h00; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 5'h0F; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t1_awready_drop", 32'(awready), 32'd0);
        chk("t1_wready_drop",  32'(wready),  32'd0);
        chk("t1_bvalid_hs",    32'(bvalid),  32'd0);
        @(posedge clk); #1;
        chk("t1_bvalid_plus1", 32'(bvalid), 32'd0);
        @(posedge clk); #1;
        chk("t1_bvalid_plus2", 32'(bvalid), 32'd1);
        chk("t1_bresp",        32'(bresp),  32'd0);
        @(posedge clk); #1;
        chk("t1_bvalid_clear",  32'(bvalid),  32'd0);
        chk("t1_awready_again", 32'(awready), 32'd1);
        read_txn(8'h00, rd, rr);
        chk("t1_rd0_data", rd, 32'hDEADBEEF);
        chk("t1_rd0_resp", 32'(rr), 32'd0);
        read_txn(8'h0C, rd, rr);
        chk("t1_wcount", rd, 32'd1);

        // W beat three cycles ahead of AW, sparse strobes
        wdata = 32'h11223344; wstrb = 5'h05; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        chk("t2_wready_drop", 32'(wready),  32'd0);
        chk("t2_awready_up",  32'(awready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("t2_wready_held", 32'(wready), 32'd0);
        chk("t2_no_bvalid",   32'(bvalid), 32'd0);
        awaddr = 8'h04; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("t2_awready_drop", 32'(awready), 32'd0);
        wait_bvalid();
        chk("t2_bresp", 32'(bresp), 32'd0);
        @(posedge clk); #1;
        read_txn(8'h04, rd, rr);
        chk("t2_rd4_data", rd, 32'h00220044);

        // Read-only and out-of-window writes, bad reads
        write_txn(8'h0C, 32'hFFFFFFFF, 5'h0F, br);
        chk("t3_wr_ro_resp", 32'(br), 32'd2);
        write_txn(8'h10, 32'h12345678, 5'h0F, br);
        chk("t3_wr_oor_resp", 32'(br), 32'd2);
        read_txn(8'h0C, rd, rr);
        chk("t3_wcount_same", rd, 32'd2);
        read_txn(8'h20, rd, rr);
        chk("t3_rd20_resp", 32'(rr), 32'd2);
        chk("t3_rd20_data", rd, 32'd0);
        read_txn(8'h02, rd, rr);
        chk("t3_rd02_resp", 32'(rr), 32'd2);
        chk("t3_rd02_data", rd, 32'd0);

        // B back-pressure blocks a second AW
        bready = 1'b0;
        start_write(8'h00, 32'h12345678, 5'h0F);
        wait_bvalid();
        awaddr = 8'h04; awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_bvalid_hold",  32'(bvalid),  32'd1);
            chk("t4_bresp_hold",   32'(bresp),   32'd0);
            chk("t4_awready_low",  32'(awready), 32'd0);
            chk("t4_wready_low",   32'(wready),  32'd0);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        chk("t4_bvalid_clear", 32'(bvalid),  32'd0);
        chk("t4_awready_open", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("t4_aw2_taken", 32'(awready), 32'd0);
        wdata = 32'h0BADF00D; wstrb = 5'h0F; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        wait_bvalid();
        chk("t4_bresp2", 32'(bresp), 32'd0);
        @(posedge clk); #1;
        read_txn(8'h04, rd, rr);
        chk("t4_rd4_data", rd, 32'h0BADF00D);
        read_txn(8'h00, rd, rr);
        chk("t4_rd0_data", rd, 32'h12345678);

        // Read captured on the commit edge returns the old value
        awaddr = 8'h08; awvalid = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 5'h0F; wvalid = 1'b1;
        bready = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        chk("t5_arready", 32'(arready), 32'd1);
        araddr = 8'h08; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("t5_rvalid",  32'(rvalid), 32'd1);
        chk("t5_rdata_old", rdata,     32'd0);
        chk("t5_rresp",   32'(rresp),  32'd0);
        chk("t5_bvalid",  32'(bvalid), 32'd1);
        @(posedge clk); #1;
        chk("t5_rvalid_clear", 32'(rvalid), 32'd0);
        chk("t5_bvalid_clear", 32'(bvalid), 32'd0);
        read_txn(8'h08, rd, rr);
        chk("t5_rdata_new", rd, 32'hA5A5A5A5);

        // Write counter wrap and all-zero strobe write
        force dut.r_wcount = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.r_wcount;
        read_txn(8'h0C, rd, rr);
        chk("t6_wcount_pre", rd, 32'hFFFFFFFF);
        write_txn(8'h00, 32'h00000001, 5'h0F, br);
        chk("t6_wrap_bresp", 32'(br), 32'd0);
        read_txn(8'h0C, rd, rr);
        chk("t6_wcount_wrap", rd, 32'd0);
        write_txn(8'h04, 32'hFFFFFFFF, 5'h00, br);
        chk("t6_zstrb_bresp", 32'(br), 32'd0);
        read_txn(8'h04, rd, rr);
        chk("t6_zstrb_data", rd, 32'h0BADF00D);
        read_txn(8'h0C, rd, rr);
        chk("t6_zstrb_count", rd, 32'd1);

        // Reset asserted while the response is pending
        bready = 1'b0;
        start_write(8'h08, 32'h5555AAAA, 5'h0F);
        wait_bvalid();
        #2;
        aresetn = 1'b0;
        #1;
        chk("t7_rst_bvalid",  32'(bvalid),  32'd0);
        chk("t7_rst_bresp",   32'(bresp),   32'd0);
        chk("t7_rst_awready", 32'(awready), 32'd0);
        chk("t7_rst_arready", 32'(arready), 32'd0);
        @(negedge clk);
        aresetn = 1'b1;
        bready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        read_txn(8'h00, rd, rr);
        chk("t7_reg0_clr", rd, 32'd0);
        read_txn(8'h04, rd, rr);
        chk("t7_reg1_clr", rd, 32'd0);
        read_txn(8'h08, rd, rr);
        chk("t7_reg2_clr", rd, 32'd0);
        read_txn(8'h0C, rd, rr);
        chk("t7_wcount_clr", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
